// File: rtl/ed_reg_pkg.sv
// Shared types and constants for the Ed25519 operand/result register bank:
// transfer FSM states, default geometry and the engine's register map.
package ed_reg_pkg;

  localparam int DEF_N_REGS = 7;
  localparam int DEF_REG_W  = 512;
  localparam int DEF_WORD_W = 32;

  localparam int REG_MSG_RX = 0;
  localparam int REG_SIG_RX = 1;
  localparam int REG_PK_RX  = 2;
  localparam int REG_SK     = 3;
  localparam int REG_PK     = 4;
  localparam int REG_MSG_TX = 5;
  localparam int REG_SIG_TX = 6;

  typedef enum logic {LD_IDLE, LD_LOAD} ld_state_t;
  typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

  // Number of serial words a register occupies; short (key-sized) registers hold half.
  function automatic int words_per_reg(input int reg_w, input int word_w, input logic is_short);
    return is_short ? reg_w / (2 * word_w) : reg_w / word_w;
  endfunction

endpackage

// File: rtl/ed_word_ctr.sv
// Word index counter for the serial loader/reader: synchronous load to zero,
// increment, and terminal-count flag against a per-transfer last index.
module ed_word_ctr #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inc,
  input  logic [CW-1:0] last_idx,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (inc) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
  assign tc  = (cnt_reg == last_idx);

endmodule

// File: rtl/ed_reg_bank.sv
// Ed25519 operand/result register bank: bulk write port, word-serial loader and
// reader, per-register valid flags. Define ED_REG_LOCK_EN to write-lock valid registers.
module ed_reg_bank
  import ed_reg_pkg::*;
#(
  parameter int                N_REGS     = DEF_N_REGS,
  parameter int                REG_W      = DEF_REG_W,
  parameter int                WORD_W     = DEF_WORD_W,
  parameter logic [N_REGS-1:0] SHORT_MASK = 7'h14,
  localparam int               AW         = $clog2(N_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [REG_W-1:0]        wr_data,
  input  logic                    ld_start,
  input  logic [AW-1:0]           ld_addr,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [WORD_W-1:0]       ld_data,
  output logic                    ld_busy,
  input  logic                    rd_start,
  input  logic [AW-1:0]           rd_addr,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [WORD_W-1:0]       rd_data,
  output logic                    rd_last,
  output logic                    rd_busy,
  input  logic                    clr_en,
  input  logic [AW-1:0]           clr_addr,
  input  logic                    clr_all,
  output logic [N_REGS-1:0]       reg_valid,
  output logic [N_REGS*REG_W-1:0] reg_q,
  output logic                    err
);

  localparam int FULL_WORDS = words_per_reg(REG_W, WORD_W, 1'b0);
  localparam int HALF_WORDS = words_per_reg(REG_W, WORD_W, 1'b1);
  localparam int CW         = $clog2(FULL_WORDS);
  localparam logic [AW:0] NREG_LIM = (AW+1)'(N_REGS);

`ifdef ED_REG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return {1'b0, a} < NREG_LIM;
  endfunction

  logic [REG_W-1:0]  reg_data [N_REGS];
  logic [N_REGS-1:0] valid_vec;
  logic              err_reg;

  ld_state_t         ld_state_reg;
  logic [AW-1:0]     ld_addr_reg;
  logic              ld_ready_reg;
  rd_state_t         rd_state_reg;
  logic [AW-1:0]     rd_addr_reg;
  logic              rd_valid_reg;
  logic              rd_last_reg;
  logic [WORD_W-1:0] rd_data_reg;

  logic          wr_locked, ld_locked;
  logic          wr_ok, ld_start_ok, rd_start_ok, ld_fire, rd_fire, err_event;
  logic [CW-1:0] ld_cnt, rd_cnt, rd_cnt_nx, ld_last_idx, rd_last_idx;
  logic          ld_tc, rd_tc;

  // A locked register is one holding complete contents; only a clear unlocks it.
  assign wr_locked   = LOCK_EN && valid_vec[wr_addr];
  assign ld_locked   = LOCK_EN && valid_vec[ld_addr];
  assign wr_ok       = wr_en && addr_ok(wr_addr) && !wr_locked;
  assign ld_start_ok = ld_start && (ld_state_reg == LD_IDLE) && addr_ok(ld_addr) && !ld_locked;
  assign rd_start_ok = rd_start && (rd_state_reg == RD_IDLE) && addr_ok(rd_addr);
  assign ld_fire     = ld_valid && ld_ready_reg;
  assign rd_fire     = rd_valid_reg && rd_ready;
  assign err_event   = (wr_en && !wr_ok) || (ld_start && !ld_start_ok) || (rd_start && !rd_start_ok);

  assign ld_last_idx = SHORT_MASK[ld_addr_reg] ? CW'(HALF_WORDS - 1) : CW'(FULL_WORDS - 1);
  assign rd_last_idx = SHORT_MASK[rd_addr_reg] ? CW'(HALF_WORDS - 1) : CW'(FULL_WORDS - 1);
  assign rd_cnt_nx   = rd_cnt + 1'b1;

  ed_word_ctr #(.CW(CW)) u_ld_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (ld_start_ok),
    .inc      (ld_fire && !ld_tc),
    .last_idx (ld_last_idx),
    .cnt      (ld_cnt),
    .tc       (ld_tc)
  );

  ed_word_ctr #(.CW(CW)) u_rd_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_start_ok),
    .inc      (rd_fire && !rd_tc),
    .last_idx (rd_last_idx),
    .cnt      (rd_cnt),
    .tc       (rd_tc)
  );

  // Storage: clear beats bulk write, bulk write beats a loader word.
  for (genvar gi = 0; gi < N_REGS; gi++) begin : g_reg
    localparam logic [REG_W-1:0] KEEP = SHORT_MASK[gi] ?
      {{(REG_W - REG_W/2){1'b0}}, {(REG_W/2){1'b1}}} : {REG_W{1'b1}};

    logic [REG_W-1:0] data_q;
    logic             valid_q;
    logic             clr_hit, wr_hit, ld_hit, ld_start_hit;

    assign clr_hit      = clr_all || (clr_en && clr_addr == AW'(gi));
    assign wr_hit       = wr_ok && wr_addr == AW'(gi);
    assign ld_hit       = ld_fire && ld_addr_reg == AW'(gi);
    assign ld_start_hit = ld_start_ok && ld_addr == AW'(gi);

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (clr_hit) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else if (wr_hit) begin
        data_q  <= wr_data & KEEP;
        valid_q <= 1'b1;
      end else begin
        if (ld_hit) begin
          data_q[ld_cnt*WORD_W +: WORD_W] <= ld_data;
        end
        if (ld_start_hit) begin
          valid_q <= 1'b0;
        end else if (ld_hit && ld_tc) begin
          valid_q <= 1'b1;
        end
      end
    end

    assign reg_data[gi]               = data_q;
    assign valid_vec[gi]              = valid_q;
    assign reg_q[gi*REG_W +: REG_W]   = data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_state_reg <= LD_IDLE;
      ld_addr_reg  <= '0;
      ld_ready_reg <= 1'b0;
    end else begin
      case (ld_state_reg)
        LD_IDLE: begin
          if (ld_start_ok) begin
            ld_state_reg <= LD_LOAD;
            ld_addr_reg  <= ld_addr;
            ld_ready_reg <= 1'b1;
          end
        end
        LD_LOAD: begin
          if (ld_fire && ld_tc) begin
            ld_state_reg <= LD_IDLE;
            ld_ready_reg <= 1'b0;
          end
        end
        default: begin
          ld_state_reg <= LD_IDLE;
          ld_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Each word is fetched from live storage when it is presented, so later writes show up.
  logic [AW-1:0]     fetch_addr;
  logic [CW-1:0]     fetch_idx;
  logic [WORD_W-1:0] fetch_word;

  always_comb begin
    fetch_addr = rd_start_ok ? rd_addr : rd_addr_reg;
    fetch_idx  = rd_start_ok ? '0 : rd_cnt_nx;
    fetch_word = reg_data[fetch_addr][fetch_idx*WORD_W +: WORD_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state_reg <= RD_IDLE;
      rd_addr_reg  <= '0;
      rd_valid_reg <= 1'b0;
      rd_last_reg  <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      case (rd_state_reg)
        RD_IDLE: begin
          if (rd_start_ok) begin
            rd_state_reg <= RD_SEND;
            rd_addr_reg  <= rd_addr;
            rd_valid_reg <= 1'b1;
            rd_data_reg  <= fetch_word;
            rd_last_reg  <= SHORT_MASK[rd_addr] ? (HALF_WORDS == 1) : (FULL_WORDS == 1);
          end
        end
        RD_SEND: begin
          if (rd_fire) begin
            if (rd_tc) begin
              rd_state_reg <= RD_IDLE;
              rd_valid_reg <= 1'b0;
              rd_last_reg  <= 1'b0;
              rd_data_reg  <= '0;
            end else begin
              rd_data_reg  <= fetch_word;
              rd_last_reg  <= (rd_cnt_nx == rd_last_idx);
            end
          end
        end
        default: begin
          rd_state_reg <= RD_IDLE;
          rd_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // A fresh error in the same cycle as clr_all still latches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= (err_reg && !clr_all) || err_event;
    end
  end

  assign ld_ready  = ld_ready_reg;
  assign ld_busy   = (ld_state_reg != LD_IDLE);
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;
  assign rd_last   = rd_last_reg;
  assign rd_busy   = (rd_state_reg != RD_IDLE);
  assign reg_valid = valid_vec;
  assign err       = err_reg;

endmodule

// File: tb/tb_ed_reg_bank.sv
// Bench for ed_reg_bank: directed scenarios with literal expectations, then random
// traffic checked every cycle against a word/array-level model of the bank.
module tb_ed_reg_bank;

  localparam int NR = 7;
  localparam int RW = 512;
  localparam int WW = 32;
  localparam int AW = 3;
  localparam int NW = RW / WW;
`ifdef ED_REG_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [RW-1:0] wr_data = '0;
  logic ld_start = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic ld_valid = 1'b0;
  logic ld_ready;
  logic [WW-1:0] ld_data = '0;
  logic ld_busy;
  logic rd_start = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic rd_valid;
  logic rd_ready = 1'b0;
  logic [WW-1:0] rd_data;
  logic rd_last, rd_busy;
  logic clr_en = 1'b0;
  logic [AW-1:0] clr_addr = '0;
  logic clr_all = 1'b0;
  logic [NR-1:0] reg_valid;
  logic [NR*RW-1:0] reg_q;
  logic err;

  always #5 clk = ~clk;

  ed_reg_bank dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld_start(ld_start), .ld_addr(ld_addr), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_busy(ld_busy),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_busy(rd_busy),
    .clr_en(clr_en), .clr_addr(clr_addr), .clr_all(clr_all),
    .reg_valid(reg_valid), .reg_q(reg_q), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [NR-1:0] short_mask = 7'h14;
  logic [RW-1:0] mm [NR];
  logic [NR-1:0] mv;
  logic          merr;
  bit            lbusy;
  int            la, lcnt;
  bit            rbusy, rvalid, rlast;
  int            ra, rk;
  logic [WW-1:0] rdata;

  function automatic int words_of(input int a);
    return short_mask[a] ? NW / 2 : NW;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) mm[i] = '0;
    mv = '0; merr = 1'b0;
    lbusy = 1'b0; la = 0; lcnt = 0;
    rbusy = 1'b0; rvalid = 1'b0; rlast = 1'b0; ra = 0; rk = 0; rdata = '0;
  endtask

  task automatic model_step();
    logic [RW-1:0] nm [NR];
    logic [NR-1:0] nv;
    int wa, lda, rda, ca;
    bit wr_ok, ld_ok, rd_ok, ld_fire, rd_fire;
    wa = int'(wr_addr); lda = int'(ld_addr); rda = int'(rd_addr); ca = int'(clr_addr);
    wr_ok   = wr_en && wa < NR && !(LOCK && mv[wa]);
    ld_ok   = ld_start && !lbusy && lda < NR && !(LOCK && mv[lda]);
    rd_ok   = rd_start && !rbusy && rda < NR;
    ld_fire = lbusy && ld_valid;
    rd_fire = rvalid && rd_ready;
    nm = mm; nv = mv;
    // lowest priority first, later updates override
    if (ld_fire) nm[la][lcnt*WW +: WW] = ld_data;
    if (ld_ok) nv[lda] = 1'b0;
    if (ld_fire && lcnt == words_of(la) - 1) nv[la] = 1'b1;
    if (wr_ok) begin
      nm[wa] = short_mask[wa] ? {256'b0, wr_data[255:0]} : wr_data;
      nv[wa] = 1'b1;
    end
    if (clr_en && ca < NR) begin nm[ca] = '0; nv[ca] = 1'b0; end
    if (clr_all) begin
      for (int i = 0; i < NR; i++) nm[i] = '0;
      nv = '0;
    end
    merr = (merr && !clr_all) || (wr_en && !wr_ok) || (ld_start && !ld_ok) || (rd_start && !rd_ok);
    if (rd_ok) begin
      rbusy = 1'b1; rvalid = 1'b1; ra = rda; rk = 0;
      rdata = mm[rda][WW-1:0]; rlast = (words_of(rda) == 1);
    end else if (rd_fire) begin
      if (rk == words_of(ra) - 1) begin
        rbusy = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      end else begin
        rk++;
        rdata = mm[ra][rk*WW +: WW];
        rlast = (rk == words_of(ra) - 1);
      end
    end
    if (ld_ok) begin
      lbusy = 1'b1; la = lda; lcnt = 0;
    end else if (ld_fire) begin
      if (lcnt == words_of(la) - 1) lbusy = 1'b0;
      else lcnt++;
    end
    mm = nm; mv = nv;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < NR; i++) chk($sformatf("reg_q[%0d]", i), reg_q[i*RW +: RW], mm[i]);
      chk("reg_valid", reg_valid, mv);
      chk("err", err, merr);
      chk("ld_ready", ld_ready, lbusy);
      chk("ld_busy", ld_busy, lbusy);
      chk("rd_valid", rd_valid, rvalid);
      chk("rd_busy", rd_busy, rbusy);
      if (rvalid) begin
        chk("rd_data", rd_data, rdata);
        chk("rd_last", rd_last, rlast);
      end
    end
  end

  // ---------------- stimulus ----------------
  int n, k;
  bit acc, held;
  logic [WW-1:0] prev_data;
  logic [WW-1:0] wv [NW];
  logic [RW-1:0] exp_v, xv, yv;

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;

    // 1: reset in the middle of a load
    @(negedge clk); ld_start = 1'b1; ld_addr = 3'd0;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 50 && n < 5; c++) begin
      ld_data = $urandom;
      if (ld_ready) n++;
      @(negedge clk);
    end
    chk("t1_words_before_reset", n, 5);
    #2 rst = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    chk("t1_reg_q0", reg_q[RW-1:0], '0);
    chk("t1_reg_q_all", reg_q[NR*RW-1:RW] == '0, 1'b1);
    chk("t1_reg_valid", reg_valid, 7'h00);
    chk("t1_ld_ready", ld_ready, 1'b0);
    chk("t1_rd_valid", rd_valid, 1'b0);
    #2 rst = 1'b1;

    // 2: serial load of short register 2 with ld_valid held
    @(negedge clk); ld_start = 1'b1; ld_addr = 3'd2;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; ld_data = 32'd1; n = 0;
    for (int c = 0; c < 20; c++) begin
      acc = ld_ready;
      if (acc) n++;
      @(negedge clk);
      if (acc) ld_data = ld_data + 32'd1;
    end
    ld_valid = 1'b0;
    chk("t2_ready_cycles", n, 8);
    chk("t2_reg2", reg_q[2*RW +: RW],
        {256'b0, 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001});
    chk("t2_valid2", reg_valid[2], 1'b1);

    // 3: bulk write then stalled readout
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd6; wr_data = {16{32'hA5A5A5A5}};
    @(negedge clk); wr_en = 1'b0; rd_start = 1'b1; rd_addr = 3'd6;
    @(negedge clk); rd_start = 1'b0;
    n = 0; held = 1'b0; rd_ready = 1'b0;
    for (int c = 0; c < 80 && n < 16; c++) begin
      rd_ready = !rd_ready;
      if (rd_valid) begin
        if (held) chk("t3_stable", rd_data, prev_data);
        chk("t3_data", rd_data, 32'hA5A5A5A5);
        chk("t3_last", rd_last, (n == 15));
        held = !rd_ready;
        prev_data = rd_data;
        if (rd_ready) n++;
      end
      @(negedge clk);
    end
    rd_ready = 1'b0;
    chk("t3_words", n, 16);
    chk("t3_rd_valid_after", rd_valid, 1'b0);

    // 4: clear beats write on the same edge; out-of-range write
    chk("t4_err_before", err, 1'b0);
    @(negedge clk); wr_en = 1'b1; wr_addr = 3'd0; wr_data = '1; clr_en = 1'b1; clr_addr = 3'd0;
    @(negedge clk); wr_en = 1'b0; clr_en = 1'b0;
    chk("t4_reg0", reg_q[RW-1:0], '0);
    chk("t4_valid0", reg_valid[0], 1'b0);
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = '1;
    @(negedge clk); wr_en = 1'b0;
    chk("t4_err_bad_addr", err, 1'b1);
    chk("t4_valid_unchanged", reg_valid, 7'h44);

    // 5: start while busy, then clr_all
    @(negedge clk); clr_all = 1'b1;
    @(negedge clk); clr_all = 1'b0;
    chk("t5_err_cleared", err, 1'b0);
    for (int w = 0; w < NW; w++) wv[w] = $urandom;
    ld_start = 1'b1; ld_addr = 3'd1;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; k = 0;
    for (int c = 0; c < 60 && k < NW; c++) begin
      ld_data = wv[k];
      ld_start = (k == 3);
      ld_addr = 3'd5;
      if (ld_ready) k++;
      @(negedge clk);
    end
    ld_valid = 1'b0; ld_start = 1'b0;
    exp_v = '0;
    for (int w = 0; w < NW; w++) exp_v[w*WW +: WW] = wv[w];
    chk("t5_err_busy", err, 1'b1);
    chk("t5_reg1", reg_q[RW +: RW], exp_v);
    chk("t5_valid", reg_valid, 7'h02);
    clr_all = 1'b1;
    @(negedge clk); clr_all = 1'b0;
    chk("t5_err_after_clr", err, 1'b0);
    chk("t5_valid_after_clr", reg_valid, 7'h00);

    // 6: overwrite of a valid register, with and without locking
    for (int w = 0; w < NW; w++) begin xv[w*WW +: WW] = $urandom; yv[w*WW +: WW] = $urandom; end
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = xv;
    @(negedge clk); wr_data = yv;
    @(negedge clk); wr_en = 1'b0;
    chk("t6_reg3_second", reg_q[3*RW +: RW], LOCK ? xv : yv);
    chk("t6_err", err, LOCK);
    clr_en = 1'b1; clr_addr = 3'd3;
    @(negedge clk); clr_en = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = yv;
    @(negedge clk); wr_en = 1'b0;
    chk("t6_reg3_after_clear", reg_q[3*RW +: RW], yv);

    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 7) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      for (int w = 0; w < NW; w++) wr_data[w*WW +: WW] = $urandom;
      ld_start = ($urandom_range(0, 15) == 0);
      ld_addr = 3'($urandom_range(0, 7));
      ld_valid = ($urandom_range(0, 2) != 0);
      ld_data = $urandom;
      rd_start = ($urandom_range(0, 15) == 0);
      rd_addr = 3'($urandom_range(0, 7));
      rd_ready = ($urandom_range(0, 2) != 0);
      clr_en = ($urandom_range(0, 31) == 0);
      clr_addr = 3'($urandom_range(0, 7));
      clr_all = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
      end
    end

    @(negedge clk);
    wr_en = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; rd_start = 1'b0; rd_ready = 1'b0;
    clr_en = 1'b0; clr_all = 1'b0;
    repeat (3) @(negedge clk);
    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
